// File: rtl/seg7_hex_driver.sv
// seg7_hex_driver: shows a 16-bit value as 4 hex digits on a multiplexed
// common-anode 7-segment display. Frame-latched shadow registers avoid
// tearing, a guard band at the start of each digit dwell suppresses
// ghosting, leading zeros can be blanked, and a 15-step PWM sets
// brightness. All outputs are registered and change on the same edge.

// Per-digit lane: hex font decode plus leading-zero blank decision.
module seg7_digit_lane #(
  parameter bit IS_LSD = 1'b0       // rightmost digit is never blanked
) (
  input  logic [3:0] nib,
  input  logic       upper_zero,    // every nibble above this one is zero
  input  logic       blank_en,
  output logic [6:0] seg_n,
  output logic       blanked
);

  // Active-low hex font, bit 0 = segment a .. bit 6 = segment g.
  always_comb begin
    seg_n = 7'h7F;
    unique case (nib)
      4'h0: seg_n = 7'h40;
      4'h1: seg_n = 7'h79;
      4'h2: seg_n = 7'h24;
      4'h3: seg_n = 7'h30;
      4'h4: seg_n = 7'h19;
      4'h5: seg_n = 7'h12;
      4'h6: seg_n = 7'h02;
      4'h7: seg_n = 7'h78;
      4'h8: seg_n = 7'h00;
      4'h9: seg_n = 7'h10;
      4'hA: seg_n = 7'h08;
      4'hB: seg_n = 7'h03;
      4'hC: seg_n = 7'h46;
      4'hD: seg_n = 7'h21;
      4'hE: seg_n = 7'h06;
      4'hF: seg_n = 7'h0E;
      default: seg_n = 7'h7F;
    endcase
  end

  assign blanked = !IS_LSD && blank_en && (nib == 4'h0) && upper_zero;

endmodule

module seg7_hex_driver #(
  parameter int DWELL = 100000,     // cycles per digit, must exceed GUARD+1
  parameter int GUARD = 64          // dark cycles at the start of each dwell
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  input  logic        blank_lz,
  input  logic [3:0]  brightness,
  output logic [3:0]  an_n,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic        frame
);

  localparam int NUM_DIGITS = 4;
  localparam int CW         = (DWELL > 1) ? $clog2(DWELL) : 1;

  // Everything latched once per frame so a digit scan never mixes two values.
  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic        blank;
  } shadow_t;

  logic [CW-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [1:0]    digit_q, digit_d;
  logic [3:0]    pwm_cnt_q, pwm_cnt_d;
  shadow_t       shadow_q, shadow_d;
  logic [3:0]    an_n_q, an_n_d;
  logic [6:0]    seg_n_q, seg_n_d;
  logic          dp_n_q, dp_n_d;
  logic          frame_q, frame_d;

  logic          dwell_wrap;
  logic          frame_start;
  logic          pwm_on;
  logic          lit;
  shadow_t       cur;

  // Frame start is the (digit 0, dwell 0) slot: reached by the 3->0 wrap or
  // by reset, which parks the counters there.
  assign dwell_wrap  = (dwell_cnt_q == CW'(DWELL - 1));
  assign frame_start = (dwell_cnt_q == '0) && (digit_q == 2'd0);
  assign pwm_on      = (pwm_cnt_q < brightness);

  // The load is visible in the frame-start slot itself, so the digit-0 dwell
  // beginning there already uses the new value even with GUARD = 0.
  assign cur = frame_start ? shadow_t'{value: value, dp: dp, blank: blank_lz}
                           : shadow_q;

  logic [NUM_DIGITS:0]             zero_above;
  logic [NUM_DIGITS-1:0][6:0]      lane_seg_n;
  logic [NUM_DIGITS-1:0]           lane_blanked;

  assign zero_above[NUM_DIGITS] = 1'b1;

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_lane
    assign zero_above[k] = (cur.value[4*k +: 4] == 4'h0) && zero_above[k+1];

    seg7_digit_lane #(
      .IS_LSD (k == 0)
    ) u_lane (
      .nib        (cur.value[4*k +: 4]),
      .upper_zero (zero_above[k+1]),
      .blank_en   (cur.blank),
      .seg_n      (lane_seg_n[k]),
      .blanked    (lane_blanked[k])
    );
  end

  // A digit lights only past the guard band, in the PWM on-phase, unblanked.
  assign lit = (dwell_cnt_q >= CW'(GUARD)) && pwm_on && !lane_blanked[digit_q];

  // Next-state for scan counters, shadow and the registered display drive.
  always_comb begin
    dwell_cnt_d = dwell_wrap ? '0 : dwell_cnt_q + 1'b1;
    digit_d     = dwell_wrap ? digit_q + 2'd1 : digit_q;
    pwm_cnt_d   = (pwm_cnt_q == 4'd14) ? 4'd0 : pwm_cnt_q + 4'd1;
    shadow_d    = cur;
    frame_d     = frame_start;
    an_n_d      = 4'hF;
    seg_n_d     = 7'h7F;
    dp_n_d      = 1'b1;
    if (lit) begin
      an_n_d  = ~(4'b0001 << digit_q);
      seg_n_d = lane_seg_n[digit_q];
      dp_n_d  = ~cur.dp[digit_q];
    end
  end

  // State and outputs; reset parks the scan at digit 0 with the display dark.
  always_ff @(posedge clk) begin
    if (reset) begin
      dwell_cnt_q <= '0;
      digit_q     <= 2'd0;
      pwm_cnt_q   <= 4'd0;
      shadow_q    <= '0;
      an_n_q      <= 4'hF;
      seg_n_q     <= 7'h7F;
      dp_n_q      <= 1'b1;
      frame_q     <= 1'b0;
    end else begin
      dwell_cnt_q <= dwell_cnt_d;
      digit_q     <= digit_d;
      pwm_cnt_q   <= pwm_cnt_d;
      shadow_q    <= shadow_d;
      an_n_q      <= an_n_d;
      seg_n_q     <= seg_n_d;
      dp_n_q      <= dp_n_d;
      frame_q     <= frame_d;
    end
  end

  assign an_n  = an_n_q;
  assign seg_n = seg_n_q;
  assign dp_n  = dp_n_q;
  assign frame = frame_q;

endmodule

// File: doc/seg7_hex_driver.md
Name: seg7_hex_driver

Overview:
- Consumes the 16-bit register value published by the AXI LED/register slave and shows it as 4 hex digits on the board's multiplexed common-anode 7-segment display.
- Provides tear-free frame latching, per-digit time multiplexing with an anti-ghost guard band, leading-zero blanking and 4-bit PWM brightness.
- Sits directly downstream of the AXI register slave, on the same clock.

Parameters:
- DWELL, 100000, clock cycles each digit is selected (1 kHz per digit at 100 MHz); must be > GUARD+1.
- GUARD, 64, cycles at the start of each dwell during which all anodes are off.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, synchronous active-high reset.
- value, in, 16, hex value to display; nibble k drives digit k (digit 0 = rightmost).
- dp, in, 4, decimal-point enables, bit k for digit k.
- blank_lz, in, 1, 1 = blank leading zero digits.
- brightness, in, 4, 0 = dark, 15 = full on.
- an_n, out, 4, digit anodes, active-low.
- seg_n, out, 7, segments a..g, active-low (seg_n[0] = a, seg_n[6] = g).
- dp_n, out, 1, decimal point, active-low.
- frame, out, 1, one-cycle pulse when shadow registers load.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset values:
  - an_n = 4'hF, seg_n = 7'h7F, dp_n = 1, frame = 0.
  - Dwell counter = 0, digit index = 0, PWM counter = 0, shadow registers = 0.
  - The first cycle after reset deasserts is treated as a frame start.
- Reset asserted mid-scan returns every output to its reset value on the next clock edge; no partial digit persists.
- Dwell counter: counts 0..DWELL-1 and wraps to 0. At the wrap, digit index advances 0→1→2→3→0.
- Frame start is the wrap of digit index from 3 to 0, plus the first post-reset cycle. At frame start:
  - shadow_value ← value, shadow_dp ← dp, shadow_blank ← blank_lz.
  - frame pulses high for exactly one cycle, registered and coincident with dwell count 0 of digit 0.
  - Changes to value, dp or blank_lz mid-frame have no effect until the next frame start, so no tearing.
- brightness is not shadowed; it is sampled every cycle.
- PWM counter: free-running 0..14, wraps to 0 after 14. pwm_on = (pwm_cnt < brightness).
  - brightness 0 → never on.
  - brightness 15 → always on, because the counter max is 14.
- Anode drive:
  - an_n[k] = 0 only when k == digit index, dwell count ≥ GUARD, pwm_on = 1 and the digit is not blanked.
  - At most one anode is low in any cycle.
- Leading-zero blanking, only when shadow_blank = 1:
  - Digit k (k = 3, 2, 1) is blanked when shadow nibbles k..3 are all zero.
  - Digit 0 is never blanked, so value 0 shows "0".
  - A blanked digit keeps its anode high even if its dp bit is set.
- Segment decode:
  - Standard hex font, active-low: 0 = 7'h40, 1 = 7'h79, 2 = 7'h24, 3 = 7'h30, 4 = 7'h19, 5 = 7'h12, 6 = 7'h02, 7 = 7'h78, 8 = 7'h00, 9 = 7'h10, A = 7'h08, b = 7'h03, C = 7'h46, d = 7'h21, E = 7'h06, F = 7'h0E.
  - dp_n = ~shadow_dp[digit index].
  - seg_n and dp_n are forced to 7'h7F / 1 whenever all anodes are high.
- Latency: all outputs are registered, 1 cycle behind the internal counters. All four outputs change on the same edge, so no glitch between anode and segments.
- Simultaneous events: a frame start and a dwell wrap always coincide; shadow load takes effect for the digit-0 dwell that begins at that edge.

Test Plan (DWELL=8, GUARD=2 unless stated):
- Reset held 5 cycles then released → an_n=F, seg_n=7F, dp_n=1 during reset; frame pulses once on the first post-reset cycle; an_n[0] goes low at dwell count 2 (registered one cycle later).
- value=16'h12AF, dp=4'b0100, brightness=15, blank_lz=0 → per frame, digit0 seg_n=0E, digit1 seg_n=08, digit2 seg_n=24 with dp_n=0, digit3 seg_n=79. Each anode is low exactly 6 of every 8 cycles and never two anodes at once.
- value=16'h0005 with blank_lz=1, then value=16'h0000 → first case: only digit 0 lights (seg_n=12), an_n[3:1] always high. Second case: digit 0 shows 40, others dark.
- value changed from 16'h1111 to 16'h2222 during the digit-2 dwell → digits 2 and 3 still show 79 for the rest of that frame; all digits show 24 after the next frame pulse.
- brightness swept 0, 1, 8, 15 with DWELL=64, GUARD=4 → anode-low duty per dwell window after the guard is 0, 1/15, 8/15 and 100% respectively (±1 PWM period).
- reset asserted while digit 2 is lit → next edge gives an_n=F, seg_n=7F; after release the scan restarts at digit 0 with a frame pulse.
